// File: rtl/vga_bounce_top_if.sv
// Pixel-write bus between the bouncing-square animator and the board's VGA simulator.
// One pixel is written per clock cycle while plot is high.
interface vga_bounce_top_if;
    logic [9:0] VGA_X;
    logic [8:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot;

    modport master (output VGA_X, VGA_Y, VGA_COLOR, plot);
    modport slave  (input  VGA_X, VGA_Y, VGA_COLOR, plot);
endinterface

// File: rtl/vga_bounce_top.sv
// Bouncing-square VGA demo: clears the screen, then loops draw / wait / erase / move,
// stepping the colour on every edge bounce. All pixel-bus outputs are registered.
module vga_bounce_top #(
    parameter int XRES        = 160,
    parameter int YRES        = 120,
    parameter int BOX         = 4,
    parameter int FRAME_TICKS = 833333
) (
    input  logic                     CLOCK_50,
    input  logic [3:0]               KEY,
    vga_bounce_top_if.master         vga
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } state_t;

    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [9:0]    X_LAST = 10'(XRES - 1);
    localparam logic [8:0]    Y_LAST = 9'(YRES - 1);
    localparam logic [9:0]    BX_MAX = 10'(XRES - BOX);
    localparam logic [8:0]    BY_MAX = 9'(YRES - BOX);
    localparam logic [9:0]    I_LAST = 10'(BOX - 1);
    localparam logic [8:0]    J_LAST = 9'(BOX - 1);
    localparam logic [TW-1:0] T_LAST = TW'(FRAME_TICKS - 1);

    logic rst;
    logic pause;
    logic unused_keys;

    assign rst         = KEY[0];
    assign pause       = KEY[1];
    assign unused_keys = ^KEY[3:2];

    state_t        state;
    logic [9:0]    cx;        // raster column during CLEAR, square offset i otherwise
    logic [8:0]    cy;        // raster row during CLEAR, square offset j otherwise
    logic [TW-1:0] tick;
    logic [9:0]    bx;
    logic [8:0]    by;
    logic          dir_x;     // 1 = moving right
    logic          dir_y;     // 1 = moving down
    logic [2:0]    colour;

    // Next-position logic for MOVE. A reversal flips the direction first and then
    // steps one pixel in the new direction, which covers both the far and near edge.
    logic       flip_x, flip_y;
    logic       dir_x_next, dir_y_next;
    logic [9:0] bx_next;
    logic [8:0] by_next;
    logic [2:0] colour_next;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        flip_x      = 1'b0;
        flip_y      = 1'b0;
        colour_next = colour;

        if (dir_x) flip_x = (bx == BX_MAX);
        else       flip_x = (bx == 10'd0);
        if (dir_y) flip_y = (by == BY_MAX);
        else       flip_y = (by == 9'd0);

        dir_x_next = dir_x ^ flip_x;
        dir_y_next = dir_y ^ flip_y;
        bx_next    = dir_x_next ? bx + 10'd1 : bx - 10'd1;
        by_next    = dir_y_next ? by + 9'd1  : by - 9'd1;

        if (flip_x || flip_y)
            colour_next = (colour == 3'd7) ? 3'd1 : colour + 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state         <= S_CLEAR;
            cx            <= '0;
            cy            <= '0;
            tick          <= '0;
            bx            <= '0;
            by            <= '0;
            dir_x         <= 1'b1;
            dir_y         <= 1'b1;
            colour        <= 3'b010;
            vga.plot      <= 1'b0;
            vga.VGA_X     <= '0;
            vga.VGA_Y     <= '0;
            vga.VGA_COLOR <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    vga.plot      <= 1'b1;
                    vga.VGA_X     <= cx;
                    vga.VGA_Y     <= cy;
                    vga.VGA_COLOR <= 3'd0;
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) begin
                            cy    <= '0;
                            state <= S_DRAW;
                        end else begin
                            cy <= cy + 9'd1;
                        end
                    end else begin
                        cx <= cx + 10'd1;
                    end
                end

                S_DRAW, S_ERASE: begin
                    vga.plot      <= 1'b1;
                    vga.VGA_X     <= bx + cx;
                    vga.VGA_Y     <= by + cy;
                    vga.VGA_COLOR <= (state == S_DRAW) ? colour : 3'd0;
                    if (cx == I_LAST) begin
                        cx <= '0;
                        if (cy == J_LAST) begin
                            cy    <= '0;
                            state <= (state == S_DRAW) ? S_WAIT : S_MOVE;
                        end else begin
                            cy <= cy + 9'd1;
                        end
                    end else begin
                        cx <= cx + 10'd1;
                    end
                end

                S_WAIT: begin
                    vga.plot <= 1'b0;
                    if (tick == T_LAST) begin
                        tick <= '0;
                        if (!pause) state <= S_ERASE;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end

                S_MOVE: begin
                    vga.plot <= 1'b0;
                    bx       <= bx_next;
                    by       <= by_next;
                    dir_x    <= dir_x_next;
                    dir_y    <= dir_y_next;
                    colour   <= colour_next;
                    state    <= S_DRAW;
                end

                default: begin
                    vga.plot <= 1'b0;
                    state    <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_bounce_top.sv
// Self-checking bench: a cycle-by-cycle expected pixel stream is built from the
// animation rules with plain integer arithmetic and compared against the DUT.
module tb_vga_bounce_top;

    localparam int XRES = 8;
    localparam int YRES = 6;
    localparam int BOX  = 2;
    localparam int FT   = 10;

    typedef struct {
        bit plot;
        int x;
        int y;
        int c;
        bit key1;
    } rec_t;

    logic       clk;
    logic [3:0] KEY;
    vga_bounce_top_if vga ();

    vga_bounce_top #(
        .XRES(XRES), .YRES(YRES), .BOX(BOX), .FRAME_TICKS(FT)
    ) dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .vga      (vga)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rec_t exp_q[$];
    int   m_bx, m_by, m_dx, m_dy, m_col;

    task automatic model_reset();
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_col = 2;
    endtask

    task automatic push(bit p, int x, int y, int c, bit k);
        rec_t r;
        r.plot = p; r.x = x; r.y = y; r.c = c; r.key1 = k;
        exp_q.push_back(r);
    endtask

    task automatic build_clear();
        for (int y = 0; y < YRES; y++)
            for (int x = 0; x < XRES; x++)
                push(1'b1, x, y, 0, 1'($urandom_range(0, 1)));
    endtask

    task automatic build_square(int c);
        for (int j = 0; j < BOX; j++)
            for (int i = 0; i < BOX; i++)
                push(1'b1, m_bx + i, m_by + j, c, 1'($urandom_range(0, 1)));
    endtask

    task automatic model_move();
        bit bounced = 0;
        if (m_dx == 1 && m_bx == XRES - BOX) begin m_dx = -1; m_bx = m_bx - 1; bounced = 1; end
        else if (m_dx == -1 && m_bx == 0)    begin m_dx = 1;  m_bx = 1;        bounced = 1; end
        else m_bx = m_bx + m_dx;
        if (m_dy == 1 && m_by == YRES - BOX) begin m_dy = -1; m_by = m_by - 1; bounced = 1; end
        else if (m_dy == -1 && m_by == 0)    begin m_dy = 1;  m_by = 1;        bounced = 1; end
        else m_by = m_by + m_dy;
        if (bounced) m_col = (m_col == 7) ? 1 : m_col + 1;
    endtask

    // holds = number of WAIT periods that end with KEY[1] high before motion resumes
    task automatic build_frame(int holds);
        build_square(m_col);
        for (int p = 0; p <= holds; p++)
            for (int t = 0; t < FT; t++)
                push(1'b0, 0, 0, 0, (t == FT - 1) ? (p < holds) : 1'($urandom_range(0, 1)));
        build_square(0);
        push(1'b0, 0, 0, 0, 1'($urandom_range(0, 1)));
        model_move();
    endtask

    // Drives KEY[1] on the falling edge before each record's rising edge and checks #1 after it.
    task automatic run_stream(string tag, int n, bit release_rst);
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            KEY[1] = exp_q[r].key1;
            if (release_rst && r == 0) KEY[0] = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (vga.plot !== exp_q[r].plot ||
                (exp_q[r].plot && (vga.VGA_X !== 10'(exp_q[r].x) ||
                                   vga.VGA_Y !== 9'(exp_q[r].y) ||
                                   vga.VGA_COLOR !== 3'(exp_q[r].c)))) begin
                errors++;
                $display("FAIL %s rec %0d: got plot=%0b x=%0d y=%0d c=%0d, expected plot=%0b x=%0d y=%0d c=%0d",
                         tag, r, vga.plot, vga.VGA_X, vga.VGA_Y, vga.VGA_COLOR,
                         exp_q[r].plot, exp_q[r].x, exp_q[r].y, exp_q[r].c);
            end
        end
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(string tag);
        checks++;
        if (vga.plot !== 1'b0 || vga.VGA_X !== 10'd0 || vga.VGA_Y !== 9'd0 || vga.VGA_COLOR !== 3'd0) begin
            errors++;
            $display("FAIL %s: got plot=%0b x=%0d y=%0d c=%0d, expected all 0",
                     tag, vga.plot, vga.VGA_X, vga.VGA_Y, vga.VGA_COLOR);
        end
    endtask

    task automatic test_reset();
        KEY = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero_outputs("reset_hold");
        end
    endtask

    task automatic test_clear();
        model_reset();
        build_clear();
        run_stream("clear", exp_q.size(), 1'b1);
    endtask

    task automatic test_bounce();
        for (int f = 0; f < 40; f++) build_frame(0);
        run_stream("bounce", exp_q.size(), 1'b0);
    endtask

    task automatic test_pause();
        build_frame(3);
        for (int f = 0; f < 6; f++) build_frame(int'($urandom_range(1, 3)));
        run_stream("pause", exp_q.size(), 1'b0);
    endtask

    task automatic test_async_reset();
        build_square(m_col);
        run_stream("draw_before_reset", 3, 1'b0);
        #4;
        KEY[0] = 1'b1;
        #1;
        check_zero_outputs("async_reset_immediate");
        @(posedge clk);
        #1;
        check_zero_outputs("async_reset_held");
        model_reset();
        build_clear();
        build_frame(0);
        run_stream("restart", exp_q.size(), 1'b1);
    endtask

    initial begin
        KEY = 4'b0001;
        test_reset();
        test_clear();
        test_bounce();
        test_pause();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
